// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
//   MIPS instruction-decode stage sitting directly behind the fetch stage.
//   Decodes the opcode into pipeline control bits and reads two operands from
//   a 32x32 register file that is written back from WB. A write in the same
//   cycle as a read is bypassed to the reader. It sign-extends the immediate
//   and registers everything into the ID/EX pipeline register (1-cycle
//   latency).
//
//   Optional feature macro: HAZARD_DETECT_EN
//     defined   : load-use stall request plus a control bubble into ID/EX
//     undefined : stall tied to 0, no bubble is ever inserted
//
// Ports
//   clock          in   1     rising-edge clock
//   reset_n        in   1     asynchronous, active-low reset
//   PC_4_in        in   PC_W  PC+4 from fetch
//   inst           in   32    instruction from fetch
//   RegWrite_wb    in   1     write-back enable
//   write_reg_wb   in   5     write-back destination register
//   write_data_wb  in   32    write-back data
//   PC_4_out       out  PC_W  ID/EX PC+4
//   read_data1     out  32    ID/EX rs value
//   read_data2     out  32    ID/EX rt value
//   sign_ext       out  32    ID/EX sign-extended inst[15:0]
//   rt_out         out  5     ID/EX inst[20:16]
//   rd_out         out  5     ID/EX inst[15:11]
//   wb_ctl         out  2     ID/EX {RegWrite, MemtoReg}
//   m_ctl          out  3     ID/EX {Branch, MemRead, MemWrite}
//   ex_ctl         out  4     ID/EX {RegDst, ALUOp[1:0], ALUSrc}
//   stall          out  1     load-use stall request to fetch (combinational)
// ---------------------------------------------------------------------------
module id_stage #(
    parameter int PC_W = 8,
    parameter int NREG = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [PC_W-1:0] PC_4_in,
    input  logic [31:0]     inst,
    input  logic            RegWrite_wb,
    input  logic [4:0]      write_reg_wb,
    input  logic [31:0]     write_data_wb,
    output logic [PC_W-1:0] PC_4_out,
    output logic [31:0]     read_data1,
    output logic [31:0]     read_data2,
    output logic [31:0]     sign_ext,
    output logic [4:0]      rt_out,
    output logic [4:0]      rd_out,
    output logic [1:0]      wb_ctl,
    output logic [2:0]      m_ctl,
    output logic [3:0]      ex_ctl,
    output logic            stall
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [31:0] r_regs [NREG];

    logic [PC_W-1:0] r_pc4;
    logic [31:0]     r_rd1;
    logic [31:0]     r_rd2;
    logic [31:0]     r_sext;
    logic [4:0]      r_rt;
    logic [4:0]      r_rd;
    logic [1:0]      r_wb;
    logic [2:0]      r_m;
    logic [3:0]      r_ex;

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [31:0] w_rsData;
    logic [31:0] w_rtData;
    logic [31:0] w_sext;
    logic [1:0]  w_wb;
    logic [2:0]  w_m;
    logic [3:0]  w_ex;
    logic        w_wbHit;
    logic        w_stall;

    assign w_op   = inst[31:26];
    assign w_rs   = inst[25:21];
    assign w_rt   = inst[20:16];
    assign w_sext = {{16{inst[15]}}, inst[15:0]};

    // A write to $0 never lands, so it must never be bypassed either.
    assign w_wbHit = RegWrite_wb && (write_reg_wb != 5'd0);

    // Opcode decode; unknown opcodes fall through as a NOP.
    always_comb begin
        w_wb = 2'b00;
        w_m  = 3'b000;
        w_ex = 4'b0000;
        case (w_op)
            OP_RTYPE: begin
                w_wb = 2'b10;
                w_ex = 4'b1100;
            end
            OP_LW: begin
                w_wb = 2'b11;
                w_m  = 3'b010;
                w_ex = 4'b0001;
            end
            OP_SW: begin
                w_m  = 3'b001;
                w_ex = 4'b0001;
            end
            OP_BEQ: begin
                w_m  = 3'b100;
                w_ex = 4'b0010;
            end
            default: begin
                w_wb = 2'b00;
            end
        endcase
    end

    // Operand read with write-before-read bypass, modelling the split-cycle
    // register file where WB writes in the first half and ID reads in the
    // second half of the same cycle.
    always_comb begin
        w_rsData = r_regs[w_rs];
        w_rtData = r_regs[w_rt];
        if (w_rs == 5'd0) begin
            w_rsData = 32'd0;
        end else if (w_wbHit && (write_reg_wb == w_rs)) begin
            w_rsData = write_data_wb;
        end
        if (w_rt == 5'd0) begin
            w_rtData = 32'd0;
        end else if (w_wbHit && (write_reg_wb == w_rt)) begin
            w_rtData = write_data_wb;
        end
    end

`ifdef HAZARD_DETECT_EN
    // A load currently in ID/EX whose destination is a source of the
    // instruction now in ID cannot be forwarded in time: ask fetch to hold.
    assign w_stall = r_m[1] && ((r_rt == w_rs) || (r_rt == w_rt));
`else
    assign w_stall = 1'b0;
`endif

    // Register file: $0 is never written, so it stays 0 from reset on.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (w_wbHit) begin
            r_regs[write_reg_wb] <= write_data_wb;
        end
    end

    // ID/EX pipeline register. While stalling, the control fields become a
    // bubble but the data fields still latch; fetch re-presents the same
    // instruction next cycle, so nothing is lost.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc4  <= '0;
            r_rd1  <= 32'd0;
            r_rd2  <= 32'd0;
            r_sext <= 32'd0;
            r_rt   <= 5'd0;
            r_rd   <= 5'd0;
            r_wb   <= 2'b00;
            r_m    <= 3'b000;
            r_ex   <= 4'b0000;
        end else begin
            r_pc4  <= PC_4_in;
            r_rd1  <= w_rsData;
            r_rd2  <= w_rtData;
            r_sext <= w_sext;
            r_rt   <= w_rt;
            r_rd   <= inst[15:11];
            if (w_stall) begin
                r_wb <= 2'b00;
                r_m  <= 3'b000;
                r_ex <= 4'b0000;
            end else begin
                r_wb <= w_wb;
                r_m  <= w_m;
                r_ex <= w_ex;
            end
        end
    end

    assign PC_4_out   = r_pc4;
    assign read_data1 = r_rd1;
    assign read_data2 = r_rd2;
    assign sign_ext   = r_sext;
    assign rt_out     = r_rt;
    assign rd_out     = r_rd;
    assign wb_ctl     = r_wb;
    assign m_ctl      = r_m;
    assign ex_ctl     = r_ex;
    assign stall      = w_stall;

endmodule
